// File: rtl/spi_dac_pkg.sv
// Shared definitions for the DAC link receiver: frame geometry, field
// positions inside an MCP4911-style write frame, FSM states and the
// configuration-bit bundle carried alongside the DAC code.
package spi_dac_pkg;

    localparam int unsigned FRAME_BITS  = 16;
    localparam int unsigned DATA_BITS   = 10;
    localparam int unsigned SYNC_STAGES = 2;

    // Bit positions within a received frame (MSB first on the wire)
    localparam int unsigned CH_BIT   = 15;
    localparam int unsigned BUF_BIT  = 14;
    localparam int unsigned GA_BIT   = 13;
    localparam int unsigned SHDN_BIT = 12;
    localparam int unsigned DATA_LSB = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic buf_en;
        logic ga_n;
        logic shdn_n;
    } dac_cfg_t;

    // Configuration bits of a complete frame
    function automatic dac_cfg_t frame_cfg(input logic [FRAME_BITS-1:0] frame);
        dac_cfg_t cfg;
        cfg.buf_en = frame[BUF_BIT];
        cfg.ga_n   = frame[GA_BIT];
        cfg.shdn_n = frame[SHDN_BIT];
        return cfg;
    endfunction

endpackage

// File: rtl/spi_dac_receiver_sync_edge.sv
// Input synchronizer with registered rise/fall pulses. The level passes
// through STAGES flops, one more flop remembers the previous level, and the
// edge pulses are registered so every event reaches the consumer STAGES+1
// cycles after the pin changes.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;
    logic              w_level;

    assign w_level = r_sync[STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

    // Metastability chain for the asynchronous pin
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    // Previous-level flop and registered single-cycle edge pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= w_level;
            r_rise <= w_level & ~r_prev;
            r_fall <= ~w_level & r_prev;
        end
    end

endmodule

// File: rtl/spi_dac_receiver.sv
// SPI responder for the DAC link. Decodes 16-bit MCP4911-style write frames
// in the sysclk domain and double-buffers them: a valid frame lands in the
// input register, an LD fall moves it to the output register.
module spi_dac_receiver #(
    parameter int unsigned FRAME_BITS  = spi_dac_pkg::FRAME_BITS,
    parameter int unsigned DATA_BITS   = spi_dac_pkg::DATA_BITS,
    parameter int unsigned SYNC_STAGES = spi_dac_pkg::SYNC_STAGES
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 dac_sck,
    input  logic                 dac_cs,
    input  logic                 dac_sdi,
    input  logic                 dac_ld,
    output logic [DATA_BITS-1:0] dac_value,
    output logic                 buf_en,
    output logic                 ga_n,
    output logic                 shdn_n,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 update
);

    import spi_dac_pkg::*;

    localparam int unsigned   CW       = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

    // Synchronized edge events
    logic w_sck_rise;
    logic w_unused_sck_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_unused_ld_rise;
    logic w_ld_fall;
    logic w_sdi;

    // Frame decode
    logic                  w_cs_end;
    logic                  w_commit;
    logic                  w_abort;
    logic                  w_xfer;
    logic [DATA_BITS-1:0]  w_new_code;
    dac_cfg_t              w_new_cfg;

    // State
    state_t                r_state;
    logic [CW-1:0]         r_count;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                  r_frame_done;
    logic                  r_frame_err;
    logic                  r_update;
    logic                  r_pending;
    logic [DATA_BITS-1:0]  r_in_code;
    dac_cfg_t              r_in_cfg;
    logic [DATA_BITS-1:0]  r_out_code;
    dac_cfg_t              r_out_cfg;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .i_clk   (sysclk),
        .i_rst_n (rst_n),
        .i_d     (dac_sck),
        .o_rise  (w_sck_rise),
        .o_fall  (w_unused_sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .i_clk   (sysclk),
        .i_rst_n (rst_n),
        .i_d     (dac_cs),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ld (
        .i_clk   (sysclk),
        .i_rst_n (rst_n),
        .i_d     (dac_ld),
        .o_rise  (w_unused_ld_rise),
        .o_fall  (w_ld_fall)
    );

    // SDI synchronizer; the extra edge-pulse flop delays SCK by one cycle,
    // which keeps the sample well inside the SDI-stable window.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdi_sync <= '0;
        end else begin
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], dac_sdi};
        end
    end

    assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

    // Frame-end classification and LD transfer decision
    always_comb begin
        w_new_code = r_shreg[DATA_LSB +: DATA_BITS];
        w_new_cfg  = frame_cfg(r_shreg);
        w_cs_end   = (r_state == ST_SHIFT) && w_cs_rise;
        w_commit   = w_cs_end && (r_count == CNT_FULL) && !r_shreg[CH_BIT];
        w_abort    = w_cs_end && !w_commit;
        // A frame committing in the same cycle counts as pending for LD
        w_xfer     = w_ld_fall && (r_pending || w_commit);
    end

    // Frame FSM: bit counter, shift register and status pulses
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_shreg      <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= w_commit;
            r_frame_err  <= w_abort;
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= ST_SHIFT;
                        r_count <= '0;
                        r_shreg <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                    end else if (w_sck_rise) begin
                        r_shreg <= {r_shreg[FRAME_BITS-2:0], w_sdi};
                        if (r_count != CNT_SAT) begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Double buffer: input register, pending flag, output register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= 1'b0;
            r_in_code  <= '0;
            r_in_cfg   <= '0;
            r_out_code <= '0;
            r_out_cfg  <= '0;
            r_update   <= 1'b0;
        end else begin
            r_update <= w_xfer;
            if (w_commit) begin
                r_in_code <= w_new_code;
                r_in_cfg  <= w_new_cfg;
            end
            if (w_xfer) begin
                r_pending  <= 1'b0;
                r_out_code <= w_commit ? w_new_code : r_in_code;
                r_out_cfg  <= w_commit ? w_new_cfg  : r_in_cfg;
            end else if (w_commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign dac_value  = r_out_cfg.shdn_n ? r_out_code : '0;
    assign buf_en     = r_out_cfg.buf_en;
    assign ga_n       = r_out_cfg.ga_n;
    assign shdn_n     = r_out_cfg.shdn_n;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign update     = r_update;

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Directed bench for spi_dac_receiver. A frame-level model (events scheduled
// at pin time plus the fixed synchronizer latency) predicts all outputs every
// cycle; literal checks pin values and pulse counts after each scenario.
module tb_spi_dac_receiver;

    localparam int unsigned S   = 2;
    localparam int unsigned LAT = S + 2;
    localparam int          H   = 5;

    logic       clk;
    logic       rst_n;
    logic       dac_sck;
    logic       dac_cs;
    logic       dac_sdi;
    logic       dac_ld;
    logic [9:0] dac_value;
    logic       buf_en;
    logic       ga_n;
    logic       shdn_n;
    logic       frame_done;
    logic       frame_err;
    logic       update;

    spi_dac_receiver #(
        .FRAME_BITS  (16),
        .DATA_BITS   (10),
        .SYNC_STAGES (S)
    ) dut (
        .sysclk     (clk),
        .rst_n      (rst_n),
        .dac_sck    (dac_sck),
        .dac_cs     (dac_cs),
        .dac_sdi    (dac_sdi),
        .dac_ld     (dac_ld),
        .dac_value  (dac_value),
        .buf_en     (buf_en),
        .ga_n       (ga_n),
        .shdn_n     (shdn_n),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .update     (update)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Model: pin-level events take effect LAT cycles after they are driven
    typedef struct {
        int unsigned cyc;
        bit          is_ld;
        int unsigned nbits;
        logic [15:0] word;
    } ev_t;

    ev_t evq[$];

    logic [9:0] m_in_code, m_out_code;
    logic [2:0] m_in_cfg,  m_out_cfg;   // {buf, ga_n, shdn_n}
    bit         m_pend;
    bit         e_done, e_err, e_upd;
    logic [15:0] exp_vec, got_vec;
    ev_t        ev;

    int n_done = 0, n_err = 0, n_upd = 0, n_both = 0;

    always @(negedge clk) begin
        e_done = 0; e_err = 0; e_upd = 0;
        if (!rst_n) begin
            m_in_code = '0; m_out_code = '0;
            m_in_cfg  = '0; m_out_cfg  = '0;
            m_pend    = 0;
            evq.delete();
        end else begin
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                ev = evq.pop_front();
                if (!ev.is_ld) begin
                    if (ev.nbits == 16 && ev.word[15] == 1'b0) begin
                        m_in_code = ev.word[11:2];
                        m_in_cfg  = ev.word[14:12];
                        m_pend    = 1;
                        e_done    = 1;
                    end else begin
                        e_err = 1;
                    end
                end else if (m_pend) begin
                    m_out_code = m_in_code;
                    m_out_cfg  = m_in_cfg;
                    m_pend     = 0;
                    e_upd      = 1;
                end
            end
        end
        exp_vec = {(m_out_cfg[0] ? m_out_code : 10'h000), m_out_cfg, e_done, e_err, e_upd};
        got_vec = {dac_value, buf_en, ga_n, shdn_n, frame_done, frame_err, update};
        n_checks++;
        if (got_vec !== exp_vec) begin
            n_errors++;
            $display("FAIL outputs cyc=%0d got=%h exp=%h (dac,buf,ga_n,shdn_n,done,err,upd)",
                     cyc, got_vec, exp_vec);
        end
        if (frame_done === 1'b1) n_done++;
        if (frame_err  === 1'b1) n_err++;
        if (update     === 1'b1) n_upd++;
        if (frame_done === 1'b1 && update === 1'b1) n_both++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_ld, input int unsigned nb, input logic [15:0] w);
        ev_t e;
        e.cyc   = cyc + LAT;
        e.is_ld = is_ld;
        e.nbits = nb;
        e.word  = w;
        evq.push_back(e);
    endtask

    task automatic ld_pulse();
        dac_ld = 1'b0;
        push(1'b1, 0, 16'h0000);
        step(H);
        dac_ld = 1'b1;
        step(H);
    endtask

    // One CS-framed burst of n SCK edges; optional LD fall at bit ld_at or with CS rise
    task automatic frame(input logic [15:0] w, input int n, input int ld_at, input bit ld_with_cs);
        logic [15:0] sh;
        sh = w;
        dac_cs = 1'b0;
        step(H);
        for (int i = 0; i < n; i++) begin
            dac_sdi = (i < 16) ? sh[15-i] : 1'b0;
            if (i == ld_at) begin
                dac_ld = 1'b0;
                push(1'b1, 0, 16'h0000);
            end
            if (i == ld_at + 1) dac_ld = 1'b1;
            step(H);
            dac_sck = 1'b1;
            step(H);
            dac_sck = 1'b0;
        end
        dac_ld = 1'b1;
        step(H);
        dac_cs = 1'b1;
        push(1'b0, n, w);
        if (ld_with_cs) begin
            dac_ld = 1'b0;
            push(1'b1, 0, 16'h0000);
        end
        step(H);
        dac_ld = 1'b1;
        step(2 * H);
    endtask

    int d0, e0, u0, b0;

    initial begin
        rst_n   = 1'b0;
        dac_sck = 1'b0;
        dac_cs  = 1'b1;
        dac_sdi = 1'b0;
        dac_ld  = 1'b1;
        step(5);
        chk("reset_state", {dac_value, buf_en, ga_n, shdn_n, frame_done, frame_err, update}, 32'h0);
        rst_n = 1'b1;
        step(10);

        // 1: full-scale code, 1x gain, active
        d0 = n_done; u0 = n_upd;
        frame(16'h3FFC, 16, -1, 1'b0);
        ld_pulse();
        chk("t1_dac", dac_value, 32'h3FF);
        chk("t1_cfg", {buf_en, ga_n, shdn_n}, 32'h3);
        chk("t1_pulses", {n_done - d0, n_upd - u0}, {32'd1, 32'd1});

        // 2: frame without LD holds old value; LD updates; second LD idle
        frame(16'h3554, 16, -1, 1'b0);
        chk("t2_hold", dac_value, 32'h3FF);
        ld_pulse();
        chk("t2_dac", dac_value, 32'h155);
        u0 = n_upd;
        ld_pulse();
        chk("t2_second_ld", n_upd - u0, 32'd0);

        // 3: wrong bit counts and channel-B frame are errors
        d0 = n_done; e0 = n_err; u0 = n_upd;
        frame(16'h3AAC, 15, -1, 1'b0);
        frame(16'h3AAC, 17, -1, 1'b0);
        frame(16'hB554, 16, -1, 1'b0);
        ld_pulse();
        chk("t3_errs", n_err - e0, 32'd3);
        chk("t3_no_done_upd", {n_done - d0, n_upd - u0}, 32'h0);
        chk("t3_dac", dac_value, 32'h155);

        // 4: shutdown forces zero; re-enable with BUF set
        frame(16'h2800, 16, -1, 1'b0);
        ld_pulse();
        chk("t4_shdn", {dac_value, shdn_n, ga_n}, {10'h000, 1'b0, 1'b1});
        frame(16'h7AAC, 16, -1, 1'b0);
        ld_pulse();
        chk("t4_dac", {dac_value, buf_en, ga_n, shdn_n}, {10'h2AB, 3'b111});

        // 5: LD falls together with CS rise
        b0 = n_both;
        frame(16'h1123, 16, -1, 1'b1);
        chk("t5_same_cycle", n_both - b0, 32'd1);
        chk("t5_dac", {dac_value, ga_n}, {10'h048, 1'b0});

        // 6: reset mid-frame
        dac_cs = 1'b0;
        step(H);
        for (int i = 0; i < 8; i++) begin
            dac_sdi = i[0];
            step(H);
            dac_sck = 1'b1;
            step(H);
            dac_sck = 1'b0;
        end
        rst_n = 1'b0;
        step(3);
        chk("t6_in_reset", {dac_value, buf_en, ga_n, shdn_n, frame_done, frame_err, update}, 32'h0);
        dac_cs = 1'b1;
        step(5);
        rst_n = 1'b1;
        step(10);
        frame(16'h30F0, 16, -1, 1'b0);
        ld_pulse();
        chk("t6_after", dac_value, 32'h03C);

        // 7: overwrite while pending; LD during SHIFT moves the previous frame
        frame(16'h3004, 16, -1, 1'b0);
        frame(16'h3008, 16, -1, 1'b0);
        ld_pulse();
        chk("t7_overwrite", dac_value, 32'h002);
        frame(16'h300C, 16, -1, 1'b0);
        frame(16'h3010, 16, 5, 1'b0);
        chk("t7_mid_ld", dac_value, 32'h003);
        ld_pulse();
        chk("t7_final", dac_value, 32'h004);

        step(10);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
